// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and widths.
package pulse_pkg;

    localparam int DIV_W_DEFAULT = 15;
    localparam int DIV_W_SIM     = 2;
    localparam int TCNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_div.sv
// Prescaler: free-running up-counter that emits a one-cycle tick when all ones.
// The counter restarts from zero whenever clear is high, so a state always
// begins with a full tick period.
module tick_div #(
    parameter int DIV_W = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count: restart on clear, otherwise wrap-around increment.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns each rising edge on an asynchronous request into an
// output pulse of ON_TICKS prescaler ticks, followed by a guaranteed low gap of
// OFF_TICKS ticks. One request arriving during a pulse or gap is remembered.
//
// state | meaning
// IDLE  | output low, waiting for an event
// ON    | output high, counting ON_TICKS ticks
// GAP   | output low, enforcing the OFF_TICKS minimum gap
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out,
    output logic busy
);

    localparam logic [TCNT_W-1:0] ON_LOAD  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LOAD = TCNT_W'(OFF_TICKS - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;

    logic ev;
    logic tick;
    logic clear;
    logic expire;

    // Synchronizer chain plus previous-value flop for edge detection.
    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer flops reset high so a level already high at release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign ev     = sync2_q & ~prev_q;
    assign expire = tick && (tcnt_q == '0);
    assign clear  = (state_d != state_q);

    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    // Next-state, pending flag, tick counter and registered output values.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d = ON;
                    tcnt_d  = ON_LOAD;
                end
            end
            ON: begin
                if (ev) begin
                    pend_d = 1'b1;
                end
                if (expire) begin
                    state_d = GAP;
                    tcnt_d  = OFF_LOAD;
                end else if (tick) begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            GAP: begin
                if (expire) begin
                    // A fresh event at expiry starts the next pulse directly;
                    // if one was already pending it is consumed and the fresh
                    // one takes its place.
                    if (pend_q || ev) begin
                        state_d = ON;
                        tcnt_d  = ON_LOAD;
                        pend_d  = pend_q & ev;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (ev) begin
                        pend_d = 1'b1;
                    end
                    if (tick) begin
                        tcnt_d = tcnt_q - TCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
                tcnt_d  = '0;
            end
        endcase

        out_d  = (state_d == ON);
        busy_d = (state_d != IDLE) || pend_d;
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            tcnt_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tcnt_q  <= tcnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch with P=4, ON_TICKS=3, OFF_TICKS=2: pulses are 12
// clocks high and followed by at least 8 clocks low.
module tb_pulse_stretch;
    import pulse_pkg::*;

    localparam int ON_T    = 3;
    localparam int OFF_T   = 2;
    localparam int P       = 4;
    localparam int ON_LEN  = ON_T * P;
    localparam int GAP_LEN = OFF_T * P;
    localparam int PERIOD  = ON_LEN + GAP_LEN;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic in_s    = 1'b0;
    logic out;
    logic busy;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     evq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int   rise_at        = 0;
    int   rises          = 0;
    int   busy_falls     = 0;
    int   last_busy_fall = -1;
    logic out_prev       = 1'b0;
    logic busy_prev      = 1'b0;

    always #5 clk = ~clk;

    pulse_stretch #(
        .DIV_W     (DIV_W_SIM),
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in_s),
        .out     (out),
        .busy    (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records each completed high phase of out, and busy falls.
    always @(negedge clk) begin
        if (out === 1'b1 && out_prev !== 1'b1) begin
            rise_at = cyc;
            rises++;
        end
        if (out === 1'b0 && out_prev === 1'b1) begin
            obs_q.push_back('{rise_at, cyc - rise_at});
        end
        if (busy === 1'b0 && busy_prev === 1'b1) begin
            busy_falls++;
            last_busy_fall = cyc;
        end
        out_prev  = out;
        busy_prev = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int rise, input int width);
        exp_q.push_back('{rise, width});
    endtask

    task automatic drain(input string tag, input int budget);
        int     n = 0;
        pulse_t e;
        pulse_t o;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            step();
            n++;
        end
        check({tag, " pulse count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, " rise cycle"}, o.rise, e.rise);
            check({tag, " width"}, o.width, e.width);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic fire();
        in_s = 1'b1;
        step();
        in_s = 1'b0;
    endtask

    initial begin
        int c;
        int r;
        int bf;
        int s;
        bit pend;
        bit prev_in;
        bit nv;
        int rate;

        // Reset state
        #1;
        reset_n = 1'b0;
        step(3);
        check("reset out", out, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;
        step(4);
        check("idle out", out, 0);
        check("idle busy", busy, 0);

        // Single one-clock request
        c = cyc;
        bf = busy_falls;
        push_exp(c + 3, ON_LEN);
        in_s = 1'b1;
        step();
        in_s = 1'b0;
        step();
        check("t1 out before 3rd edge", out, 0);
        step();
        check("t1 out at 3rd edge", out, 1);
        check("t1 busy at 3rd edge", busy, 1);
        step(30);
        drain("t1", 10);
        check("t1 busy fall delay", last_busy_fall - (c + 3 + ON_LEN), GAP_LEN);
        check("t1 busy fall count", busy_falls - bf, 1);

        // Three events during ON merge into one further pulse
        c = cyc;
        r = c + 3;
        bf = busy_falls;
        push_exp(r, ON_LEN);
        push_exp(r + PERIOD, ON_LEN);
        fire();
        wait_until(r + 2);
        fire();
        wait_until(r + 5);
        fire();
        wait_until(r + 8);
        fire();
        wait_until(r + 2 * PERIOD + 20);
        drain("t2", 10);
        check("t2 busy fall cycle", last_busy_fall, r + 2 * PERIOD);
        check("t2 busy fall count", busy_falls - bf, 1);

        // Event coincident with ON expiry becomes pending
        c = cyc;
        r = c + 3;
        bf = busy_falls;
        push_exp(r, ON_LEN);
        push_exp(r + PERIOD, ON_LEN);
        fire();
        wait_until(r + ON_LEN - 3);
        fire();
        wait_until(r + 2 * PERIOD + 20);
        drain("t3 on-expiry", 10);
        check("t3 busy fall cycle", last_busy_fall, r + 2 * PERIOD);
        check("t3 busy fall count", busy_falls - bf, 1);

        // Event coincident with GAP expiry, nothing pending: straight to ON
        c = cyc;
        r = c + 3;
        bf = busy_falls;
        push_exp(r, ON_LEN);
        push_exp(r + PERIOD, ON_LEN);
        fire();
        wait_until(r + PERIOD - 3);
        fire();
        wait_until(r + PERIOD - 1);
        check("t4 out before gap expiry", out, 0);
        step();
        check("t4 out at gap expiry", out, 1);
        wait_until(r + 2 * PERIOD + 20);
        drain("t4 gap-expiry", 10);
        check("t4 busy fall cycle", last_busy_fall, r + 2 * PERIOD);
        check("t4 busy fall count", busy_falls - bf, 1);

        // Event coincident with GAP expiry while pending: pending survives
        c = cyc;
        r = c + 3;
        bf = busy_falls;
        push_exp(r, ON_LEN);
        push_exp(r + PERIOD, ON_LEN);
        push_exp(r + 2 * PERIOD, ON_LEN);
        fire();
        wait_until(r + 2);
        fire();
        wait_until(r + PERIOD - 3);
        fire();
        wait_until(r + 3 * PERIOD + 20);
        drain("t5 pending-expiry", 10);
        check("t5 busy fall cycle", last_busy_fall, r + 3 * PERIOD);
        check("t5 busy fall count", busy_falls - bf, 1);

        // Reset pulsed mid-ON
        c = cyc;
        r = c + 3;
        bf = busy_falls;
        push_exp(r, 5);
        fire();
        wait_until(r + 5);
        reset_n = 1'b0;
        #1;
        check("t6 out during reset", out, 0);
        check("t6 busy during reset", busy, 0);
        step();
        reset_n = 1'b1;
        step(40);
        check("t6 out after release", out, 0);
        check("t6 busy after release", busy, 0);
        drain("t6 reset mid-on", 5);
        check("t6 busy fall count", busy_falls - bf, 1);

        // Level high at reset release is not an event
        in_s = 1'b1;
        step();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        c = rises;
        step(50);
        check("t7 no pulse from held level", rises - c, 0);
        check("t7 out held level", out, 0);
        check("t7 busy held level", busy, 0);
        in_s = 1'b0;
        step(3);
        c = cyc;
        push_exp(c + 3, ON_LEN);
        fire();
        step(30);
        drain("t7 after low-high", 10);

        // Random request stream against an interval reference model
        prev_in = 1'b0;
        in_s = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            rate = (i < 5000) ? 6 : 30;
            nv = prev_in;
            if ($urandom_range(rate - 1, 0) == 0) nv = ~prev_in;
            in_s = nv;
            if (nv && !prev_in) evq.push_back(cyc + 3);
            prev_in = nv;
            step();
        end
        in_s = 1'b0;
        step(3 * PERIOD);

        s = -1000;
        pend = 1'b0;
        foreach (evq[k]) begin
            if (pend && s + PERIOD < evq[k]) begin
                s = s + PERIOD;
                push_exp(s, ON_LEN);
                pend = 1'b0;
            end
            if (pend && s + PERIOD == evq[k]) begin
                s = s + PERIOD;
                push_exp(s, ON_LEN);
            end else if (pend) begin
                pend = 1'b1;
            end else if (evq[k] >= s + PERIOD) begin
                s = evq[k];
                push_exp(s, ON_LEN);
            end else begin
                pend = 1'b1;
            end
        end
        if (pend) push_exp(s + PERIOD, ON_LEN);

        for (int i = 1; i < obs_q.size(); i++) begin
            check("rand low gap >= 8",
                  (obs_q[i].rise - (obs_q[i-1].rise + obs_q[i-1].width)) >= GAP_LEN, 1);
        end
        drain("rand", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter DIV_W, default 15: prescaler width; tick period P = 2^DIV_W clk cycles (2 for simulation).
REQ-002 Parameter ON_TICKS, default 8: output-high duration in ticks; legal range 1..255.
REQ-003 Parameter OFF_TICKS, default 8: minimum output-low gap in ticks; legal range 1..255.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  1  event request, possibly asynchronous to clk; rising edge = one event.
REQ-007 out  output  1  stretched pulse, registered, active-high.
REQ-008 busy  output  1  registered; high when state != IDLE or an event is pending.

Function
REQ-009 in passes through a two-flop synchronizer; a third flop holds the previous synchronized value; event = sync & ~prev.
REQ-010 FSM states: IDLE, ON, GAP; out = 1 exactly while in state ON.
REQ-011 IDLE + event -> ON at the same edge; out rises after the 3rd clk edge following in rising, given in is stable high across those edges.
REQ-012 Prescaler: DIV_W-bit up-counter, cleared on every state transition; tick asserted for one cycle when counter is all ones.
REQ-013 Tick counter: 8 bits, loaded with ON_TICKS-1 on entry to ON and OFF_TICKS-1 on entry to GAP; decrements on each tick; state exits on a tick when the counter is 0.
REQ-014 ON therefore lasts exactly ON_TICKS*P cycles; GAP lasts exactly OFF_TICKS*P cycles.
REQ-015 ON expiry -> GAP.
REQ-016 GAP expiry -> ON if pending = 1 (pending cleared at the same edge); otherwise -> IDLE.
REQ-017 An event in ON or GAP sets pending; pending is one-deep; further events while pending = 1 are merged.
REQ-018 Event coincident with ON expiry: sets pending; FSM enters GAP.
REQ-019 Event coincident with GAP expiry while pending = 0: FSM enters ON directly, not IDLE; pending stays 0.
REQ-020 Event coincident with GAP expiry while pending = 1: FSM enters ON with pending left at 1.
REQ-021 in held high continuously produces exactly one event.

Reset
REQ-022 reset_n low forces asynchronously: state IDLE, out 0, busy 0, pending 0, prescaler 0, tick counter 0, synchronizer flops 1, prev 1.
REQ-023 A level on in that is already high at reset release produces no event; an event requires a low-then-high transition after release.
REQ-024 Reset asserted mid-ON or mid-GAP discards the pulse and any pending event, with no residual output after release.

Structure
REQ-025 Shared package pulse_pkg holds: state encoding (IDLE=2'd0, ON=2'd1, GAP=2'd2), default DIV_W (15), simulation DIV_W (2), and tick-counter width (8).
REQ-026 Sub-module tick_div implements the prescaler, with inputs clk, reset_n and clear, and output tick.
REQ-027 All other logic lives in pulse_stretch; no latches; no derived clocks; tick is used only as an enable.

Verification (DIV_W=2, P=4, ON_TICKS=3, OFF_TICKS=2)
REQ-028 in held high 1 clk from idle -> out high after 3rd edge, high for exactly 12 clks, then low; busy falls 8 clks after out falls.
REQ-029 Three events during ON -> one further pulse only: out low for exactly 8 clks, then high for 12, then IDLE.
REQ-030 Event on the same cycle as GAP expiry with pending = 0 -> out rises at that edge, with no IDLE cycle in between.
REQ-031 reset_n pulsed low mid-ON for 1 clk -> out drops immediately; busy = 0; no pulse after release while in stays low.
REQ-032 in high at reset release and held high for 50 clks -> out stays 0; subsequent low-then-high on in -> normal 12-clk pulse.
REQ-033 Random event stream over 10k clks -> every high phase of out is 12 clks, every low gap between pulses is >= 8 clks, and pulse count equals the reference-model count.
